// File: rtl/ecc_apb_sequencer_if.sv
// APB register bus (no PREADY/PSLVERR) between a host and ecc_apb_sequencer.
interface ecc_apb_sequencer_if #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32
);
  logic [AMBA_ADDR_WIDTH-1:0] paddr;
  logic [AMBA_WORD-1:0]       pwdata;
  logic                       psel;
  logic                       penable;
  logic                       pwrite;
  logic [AMBA_WORD-1:0]       prdata;

  modport master (output paddr, pwdata, psel, penable, pwrite, input prdata);
  modport slave  (input paddr, pwdata, psel, penable, pwrite, output prdata);
endinterface

// File: rtl/ecc_apb_sequencer.sv
// APB-programmed sequencer that launches one ECC datapath operation at a time and captures its result.
// Optional datapath watchdog is compiled in when ECC_SEQ_TIMEOUT_EN is defined.
module ecc_apb_sequencer #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT         = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  ecc_apb_sequencer_if.slave    apb,
  output logic                  op_start,
  output logic [1:0]            op_mode,
  output logic [DATA_WIDTH-1:0] op_data,
  output logic [1:0]            op_width,
  output logic [DATA_WIDTH-1:0] op_noise,
  input  logic                  dp_done,
  input  logic [DATA_WIDTH-1:0] dp_data,
  input  logic [1:0]            dp_num_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  operation_done,
  output logic [1:0]            num_of_errors
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_e;

  localparam logic [2:0]  REG_CTRL     = 3'd0;
  localparam logic [2:0]  REG_DATA_IN  = 3'd1;
  localparam logic [2:0]  REG_WIDTH    = 3'd2;
  localparam logic [2:0]  REG_NOISE    = 3'd3;
  localparam logic [2:0]  REG_STATUS   = 3'd4;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [1:0]            width_q, width_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [1:0]            nerr_q, nerr_d;
  logic                  done_q, done_d;
  logic                  wr_err_q, wr_err_d;
  logic [AMBA_WORD-1:0]  prdata_q, prdata_d;
  logic                  timeout_flag;

`ifdef ECC_SEQ_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_q, timeout_d;
  logic        timeout_set;
  assign timeout_flag = timeout_q;
`else
  assign timeout_flag = 1'b0;
`endif

  logic [2:0]           reg_sel;
  logic                 wr_access, rd_setup, rd_access;
  logic                 width_ok, ctrl_ok;
  logic                 done_set, wr_err_set;
  logic [AMBA_WORD-1:0] status_word, rd_mux;
  logic                 unused_bus;

  assign reg_sel   = apb.paddr[4:2];
  assign wr_access = apb.psel &  apb.penable &  apb.pwrite;
  assign rd_setup  = apb.psel & ~apb.penable & ~apb.pwrite;
  assign rd_access = apb.psel &  apb.penable & ~apb.pwrite;

  // Bits and parameters with no logic behind them in every configuration.
  assign unused_bus = ^{apb.paddr, apb.pwdata, TIMEOUT_LAST, 8'(AMBA_ADDR_WIDTH)};

  assign width_ok = (width_q == 2'd0)
                  | ((width_q == 2'd1) & (DATA_WIDTH >= 16))
                  | ((width_q == 2'd2) & (DATA_WIDTH >= 32));
  assign ctrl_ok  = (apb.pwdata[1:0] != 2'd3) & width_ok;

  always_comb begin
    status_word      = '0;
    status_word[0]   = (state_q != S_IDLE);
    status_word[1]   = done_q;
    status_word[3:2] = nerr_q;
    status_word[4]   = timeout_flag;
    status_word[5]   = wr_err_q;
  end

  always_comb begin
    rd_mux = '0;
    unique case (reg_sel)
      REG_CTRL:    rd_mux[1:0]            = mode_q;
      REG_DATA_IN: rd_mux[DATA_WIDTH-1:0] = data_in_q;
      REG_WIDTH:   rd_mux[1:0]            = width_q;
      REG_NOISE:   rd_mux[DATA_WIDTH-1:0] = noise_q;
      REG_STATUS:  rd_mux                 = status_word;
      default:     rd_mux                 = '0;
    endcase
  end

  // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    width_d    = width_q;
    data_in_d  = data_in_q;
    noise_d    = noise_q;
    data_out_d = data_out_q;
    nerr_d     = nerr_q;
    done_d     = done_q;
    wr_err_d   = wr_err_q;
    prdata_d   = prdata_q;
    done_set   = 1'b0;
    wr_err_set = 1'b0;
`ifdef ECC_SEQ_TIMEOUT_EN
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
    timeout_set = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (wr_access) begin
          unique case (reg_sel)
            REG_CTRL: begin
              if (ctrl_ok) begin
                mode_d  = apb.pwdata[1:0];
                state_d = S_LAUNCH;
              end else begin
                wr_err_set = 1'b1;
              end
            end
            REG_DATA_IN: data_in_d = apb.pwdata[DATA_WIDTH-1:0];
            REG_WIDTH:   width_d   = apb.pwdata[1:0];
            REG_NOISE:   noise_d   = apb.pwdata[DATA_WIDTH-1:0];
            default:     ;
          endcase
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef ECC_SEQ_TIMEOUT_EN
        wd_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (dp_done) begin
          data_out_d = dp_data;
          nerr_d     = dp_num_err;
          state_d    = S_DONE;
        end
`ifdef ECC_SEQ_TIMEOUT_EN
        else if (wd_cnt_q == TIMEOUT_LAST) begin
          timeout_set = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + 16'd1;
        end
`endif
      end
      S_DONE: begin
        done_set = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The register file is frozen while an operation is in flight.
    if (wr_access && (state_q != S_IDLE)) wr_err_set = 1'b1;

    if (rd_setup) prdata_d = rd_mux;

    // Read-to-clear happens first so a flag raised in the same cycle survives.
    if (rd_access && (reg_sel == REG_STATUS)) begin
      done_d   = 1'b0;
      wr_err_d = 1'b0;
`ifdef ECC_SEQ_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
    end
    if (done_set)   done_d   = 1'b1;
    if (wr_err_set) wr_err_d = 1'b1;
`ifdef ECC_SEQ_TIMEOUT_EN
    if (timeout_set) timeout_d = 1'b1;
`endif
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      width_q    <= '0;
      data_in_q  <= '0;
      noise_q    <= '0;
      data_out_q <= '0;
      nerr_q     <= '0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      prdata_q   <= '0;
`ifdef ECC_SEQ_TIMEOUT_EN
      wd_cnt_q   <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      width_q    <= width_d;
      data_in_q  <= data_in_d;
      noise_q    <= noise_d;
      data_out_q <= data_out_d;
      nerr_q     <= nerr_d;
      done_q     <= done_d;
      wr_err_q   <= wr_err_d;
      prdata_q   <= prdata_d;
`ifdef ECC_SEQ_TIMEOUT_EN
      wd_cnt_q   <= wd_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign apb.prdata     = prdata_q;
  assign op_start       = (state_q == S_LAUNCH);
  assign operation_done = (state_q == S_DONE);
  assign op_mode        = mode_q;
  assign op_width       = width_q;
  assign op_data        = data_in_q;
  assign op_noise       = noise_q;
  assign data_out       = data_out_q;
  assign num_of_errors  = nerr_q;

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Directed bench for ecc_apb_sequencer: register table plus hand-written operation sequences.
module tb_ecc_apb_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [31:0] A_CTRL  = 32'h00;
  localparam logic [31:0] A_DIN   = 32'h04;
  localparam logic [31:0] A_WID   = 32'h08;
  localparam logic [31:0] A_NOISE = 32'h0C;
  localparam logic [31:0] A_STAT  = 32'h10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ecc_apb_sequencer_if #(.AMBA_ADDR_WIDTH(AW), .AMBA_WORD(32)) apb ();

  logic          op_start, operation_done, dp_done;
  logic [1:0]    op_mode, op_width, dp_num_err, num_of_errors;
  logic [DW-1:0] op_data, op_noise, dp_data, data_out;

  ecc_apb_sequencer #(
    .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(32), .DATA_WIDTH(DW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .apb(apb),
    .op_start(op_start), .op_mode(op_mode), .op_data(op_data),
    .op_width(op_width), .op_noise(op_noise),
    .dp_done(dp_done), .dp_data(dp_data), .dp_num_err(dp_num_err),
    .data_out(data_out), .operation_done(operation_done), .num_of_errors(num_of_errors)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int done_pulses  = 0;
  int start_pulses = 0;

  always @(posedge clk) begin
    if (operation_done) done_pulses  = done_pulses + 1;
    if (op_start)       start_pulses = start_pulses + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the access edge.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    apb.paddr = addr; apb.pwdata = data; apb.pwrite = 1'b1;
    apb.psel = 1'b1; apb.penable = 1'b0;
    @(negedge clk) apb.penable = 1'b1;
    @(negedge clk) begin apb.psel = 1'b0; apb.penable = 1'b0; end
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    apb.paddr = addr; apb.pwrite = 1'b0;
    apb.psel = 1'b1; apb.penable = 1'b0;
    @(negedge clk) apb.penable = 1'b1;
    data = apb.prdata;
    @(negedge clk) begin apb.psel = 1'b0; apb.penable = 1'b0; end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          s, d;

    apb.paddr = '0; apb.pwdata = '0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    dp_done = 1'b0; dp_data = '0; dp_num_err = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_op_start", op_start, 0);
    check("rst_op_done", operation_done, 0);
    check("rst_data_out", data_out, 0);
    check("rst_prdata", apb.prdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Reserved mode in IDLE: no launch, only wr_err
    s = start_pulses;
    apb_write(A_CTRL, 32'h3);
    @(negedge clk);
    check("ctrl3_no_start", start_pulses, s);
    apb_read(A_STAT, rd); check("ctrl3_status", rd, 32'h20);
    apb_read(A_STAT, rd); check("ctrl3_status_clr", rd, 32'h00);

    // Register table
    vecs[0]  = '{1'b1, A_DIN,        32'h1234_5678, "din_wr"};
    vecs[1]  = '{1'b0, A_DIN,        32'h1234_5678, "din_rd"};
    vecs[2]  = '{1'b0, 32'h0000_1004, 32'h1234_5678, "din_alias_rd"};
    vecs[3]  = '{1'b1, A_NOISE,      32'h0000_0011, "noise_wr"};
    vecs[4]  = '{1'b0, A_NOISE,      32'h0000_0011, "noise_rd"};
    vecs[5]  = '{1'b1, A_WID,        32'h0000_0002, "wid_wr"};
    vecs[6]  = '{1'b0, A_WID,        32'h0000_0002, "wid_rd"};
    vecs[7]  = '{1'b1, A_WID,        32'hFFFF_FFFF, "wid3_wr"};
    vecs[8]  = '{1'b0, A_WID,        32'h0000_0003, "wid3_rd"};
    vecs[9]  = '{1'b1, A_CTRL,       32'h0000_0000, "ctrl_badwid_wr"};
    vecs[10] = '{1'b0, A_STAT,       32'h0000_0020, "badwid_status"};
    vecs[11] = '{1'b0, A_STAT,       32'h0000_0000, "badwid_status_clr"};
    vecs[12] = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, "off5_wr"};
    vecs[13] = '{1'b0, 32'h0000_0014, 32'h0000_0000, "off5_rd"};
    vecs[14] = '{1'b0, 32'h0000_001C, 32'h0000_0000, "off7_rd"};
    vecs[15] = '{1'b1, A_WID,        32'h0000_0000, "wid0_wr"};
    vecs[16] = '{1'b0, A_STAT,       32'h0000_0000, "idle_status"};
    s = start_pulses;
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
      else begin
        apb_read(vecs[i].addr, rd);
        check(vecs[i].name, rd, vecs[i].data);
      end
    end
    check("table_no_start", start_pulses, s);

    // Encode: dp_done two cycles after op_start
    d = done_pulses;
    apb_write(A_DIN, 32'h0000_00A5);
    apb_write(A_WID, 32'h0);
    apb_write(A_CTRL, 32'h0);
    check("enc_op_start", op_start, 1);
    check("enc_op_mode", op_mode, 0);
    check("enc_op_data", op_data, 32'hA5);
    check("enc_op_width", op_width, 0);
    @(negedge clk);
    check("enc_start_1cyc", op_start, 0);
    @(negedge clk);
    dp_done = 1'b1; dp_data = 32'h1A5; dp_num_err = 2'd0;
    @(negedge clk);
    dp_done = 1'b0;
    check("enc_op_done", operation_done, 1);
    check("enc_data_out", data_out, 32'h1A5);
    @(negedge clk);
    check("enc_op_done_low", operation_done, 0);
    check("enc_done_once", done_pulses, d + 1);
    apb_read(A_STAT, rd); check("enc_status", rd, 32'h02);

    // Decode with two reported errors
    apb_write(A_DIN, 32'h0000_01A5);
    apb_write(A_CTRL, 32'h1);
    check("dec_op_mode", op_mode, 1);
    @(negedge clk);
    dp_done = 1'b1; dp_data = 32'hA5; dp_num_err = 2'd2;
    @(negedge clk);
    dp_done = 1'b0;
    check("dec_op_done", operation_done, 1);
    check("dec_nerr", num_of_errors, 2);
    check("dec_data_out", data_out, 32'hA5);
    @(negedge clk);
    apb_read(A_STAT, rd); check("dec_status", rd, 32'h0A);
    apb_read(A_STAT, rd); check("dec_status_clr", rd, 32'h08);

    // Writes while busy, including a CTRL write in the dp_done cycle
    apb_write(A_NOISE, 32'h0001_0000);
    apb_write(A_CTRL, 32'h2);
    check("full_op_mode", op_mode, 2);
    check("full_op_noise", op_noise, 32'h0001_0000);
    apb_write(A_DIN, 32'h55);
    check("busy_op_data", op_data, 32'h1A5);
    apb_read(A_STAT, rd); check("busy_status", rd, 32'h29);
    apb.paddr = A_CTRL; apb.pwdata = 32'h0; apb.pwrite = 1'b1;
    apb.psel = 1'b1; apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    dp_done = 1'b1; dp_data = 32'h3C; dp_num_err = 2'd1;
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0; dp_done = 1'b0;
    check("race_op_done", operation_done, 1);
    check("race_data_out", data_out, 32'h3C);
    check("race_nerr", num_of_errors, 1);
    s = start_pulses;
    @(negedge clk);
    @(negedge clk);
    check("race_no_launch", start_pulses, s);
    check("race_op_mode", op_mode, 2);
    apb_read(A_STAT, rd); check("race_status", rd, 32'h26);

    // Reset one cycle after op_start aborts the operation
    apb_write(A_CTRL, 32'h0);
    check("abort_launch", op_start, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_op_data", op_data, 0);
    check("abort_op_noise", op_noise, 0);
    check("abort_data_out", data_out, 0);
    check("abort_nerr", num_of_errors, 0);
    check("abort_prdata", apb.prdata, 0);
    check("abort_op_start", op_start, 0);
    d = done_pulses;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dp_done = 1'b1; dp_data = 32'hFF; dp_num_err = 2'd3;
    @(negedge clk);
    dp_done = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_pulses, d);
    check("abort_data_hold", data_out, 0);
    apb_read(A_STAT, rd); check("abort_status", rd, 32'h00);

    // Datapath never answers
    d = done_pulses;
    apb_write(A_CTRL, 32'h0);
    repeat (7) @(negedge clk);
    apb_read(A_STAT, rd); check("wd_busy", rd, 32'h01);
`ifdef ECC_SEQ_TIMEOUT_EN
    apb_read(A_STAT, rd); check("wd_timeout", rd, 32'h10);
    apb_read(A_STAT, rd); check("wd_timeout_clr", rd, 32'h00);
`else
    apb_read(A_STAT, rd); check("wd_still_busy", rd, 32'h01);
    repeat (20) @(negedge clk);
    apb_read(A_STAT, rd); check("wd_no_timeout", rd, 32'h01);
`endif
    check("wd_no_done", done_pulses, d);
    check("wd_data_hold", data_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
